// File: rtl/conveyor_writer_if.sv
// Conveyor write-side bundle: slot reservations, completion sources and the single write port.
interface conveyor_writer_if #(
  parameter int unsigned WORD_WIDTH          = 32,
  parameter int unsigned CONVEYOR_ADDR_WIDTH = 4,
  parameter int unsigned FAULT_ADDR_WIDTH    = 3,
  parameter int unsigned SOURCES             = 2
);
  logic                                    reserve;
  logic                                    reserve_conv;
  logic [CONVEYOR_ADDR_WIDTH-1:0]          reserve_slot;
  logic [SOURCES-1:0]                      src_valid;
  logic [SOURCES-1:0]                      src_ready;
  logic [SOURCES-1:0]                      src_conv;
  logic [SOURCES*CONVEYOR_ADDR_WIDTH-1:0]  src_slot;
  logic [SOURCES*WORD_WIDTH-1:0]           src_value;
  logic [SOURCES*FAULT_ADDR_WIDTH-1:0]     src_fault;
  logic                                    wr_en;
  logic                                    wr_conv;
  logic [CONVEYOR_ADDR_WIDTH-1:0]          wr_slot;
  logic [FAULT_ADDR_WIDTH+WORD_WIDTH:0]    wr_data;

  modport master (
    output reserve, reserve_conv, reserve_slot,
    output src_valid, src_conv, src_slot, src_value, src_fault,
    input  src_ready,
    input  wr_en, wr_conv, wr_slot, wr_data
  );

  modport slave (
    input  reserve, reserve_conv, reserve_slot,
    input  src_valid, src_conv, src_slot, src_value, src_fault,
    output src_ready,
    output wr_en, wr_conv, wr_slot, wr_data
  );
endinterface

// File: rtl/conveyor_writer.sv
// Producer-side conveyor port: reservations write placeholders, completions are round-robin
// arbitrated into a small FIFO that drains through the shared write port.
module conveyor_writer #(
  parameter int unsigned WORD_WIDTH          = 32,
  parameter int unsigned CONVEYOR_ADDR_WIDTH = 4,
  parameter int unsigned FAULT_ADDR_WIDTH    = 3,
  parameter int unsigned SOURCES             = 2,
  parameter int unsigned FIFO_ADDR_WIDTH     = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  conveyor_writer_if.slave               bus,
  output logic [CONVEYOR_ADDR_WIDTH:0]   outstanding0_o,
  output logic [CONVEYOR_ADDR_WIDTH:0]   outstanding1_o,
  output logic                           protocol_error_o
);
  localparam int unsigned FifoDepth = 1 << FIFO_ADDR_WIDTH;
  localparam int unsigned EntryW    = 1 + CONVEYOR_ADDR_WIDTH + FAULT_ADDR_WIDTH + WORD_WIDTH;
  localparam int unsigned PayloadW  = FAULT_ADDR_WIDTH + WORD_WIDTH;
  localparam int unsigned SrcW      = (SOURCES > 1) ? $clog2(SOURCES) : 1;
  localparam logic [FIFO_ADDR_WIDTH:0]     FifoFull = {1'b1, {FIFO_ADDR_WIDTH{1'b0}}};
  localparam logic [CONVEYOR_ADDR_WIDTH:0] CntMax   = {1'b1, {CONVEYOR_ADDR_WIDTH{1'b0}}};

  logic [EntryW-1:0]              mem_q [FifoDepth];
  logic [FIFO_ADDR_WIDTH-1:0]     wr_ptr_q, rd_ptr_q;
  logic [FIFO_ADDR_WIDTH:0]       count_q, count_d;
  logic [SrcW-1:0]                rr_q, rr_d;
  logic [CONVEYOR_ADDR_WIDTH:0]   cnt_q [2];
  logic [CONVEYOR_ADDR_WIDTH:0]   cnt_d [2];
  logic                           err_q, err_d;

  logic                           res_eff, empty, full, pop, push;
  logic                           gnt_found;
  logic [SrcW-1:0]                gnt_idx, cand;
  logic [EntryW-1:0]              head, push_entry;
  logic                           head_conv;
  logic [1:0]                     inc, dec;

  assign res_eff   = ~reset & bus.reserve;
  assign empty     = (count_q == '0);
  assign full      = (count_q == FifoFull);
  assign head      = mem_q[rd_ptr_q];
  assign head_conv = head[EntryW-1];
  // Reservation owns the write port; the FIFO only drains on cycles without one.
  assign pop       = ~reset & ~bus.reserve & ~empty;

  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    cand      = '0;
    for (int unsigned i = 0; i < SOURCES; i++) begin
      cand = SrcW'((32'(rr_q) + i) % SOURCES);
      if (!gnt_found && bus.src_valid[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  assign push       = ~reset & gnt_found & (~full | pop);
  assign push_entry = {bus.src_conv[gnt_idx],
                       bus.src_slot[gnt_idx*CONVEYOR_ADDR_WIDTH +: CONVEYOR_ADDR_WIDTH],
                       bus.src_fault[gnt_idx*FAULT_ADDR_WIDTH +: FAULT_ADDR_WIDTH],
                       bus.src_value[gnt_idx*WORD_WIDTH +: WORD_WIDTH]};

  always_comb begin
    bus.src_ready = '0;
    if (push) bus.src_ready[gnt_idx] = 1'b1;
    rr_d = rr_q;
    if (push) rr_d = (32'(gnt_idx) == SOURCES - 1) ? '0 : gnt_idx + 1'b1;
    count_d = count_q;
    if (push && !pop) count_d = count_q + 1'b1;
    else if (pop && !push) count_d = count_q - 1'b1;
  end

  always_comb begin
    bus.wr_en   = 1'b0;
    bus.wr_conv = 1'b0;
    bus.wr_slot = '0;
    bus.wr_data = '0;
    if (res_eff) begin
      bus.wr_en   = 1'b1;
      bus.wr_conv = bus.reserve_conv;
      bus.wr_slot = bus.reserve_slot;
    end else if (pop) begin
      bus.wr_en   = 1'b1;
      bus.wr_conv = head_conv;
      bus.wr_slot = head[PayloadW +: CONVEYOR_ADDR_WIDTH];
      bus.wr_data = {1'b1, head[PayloadW-1:0]};
    end
  end

  assign inc = {res_eff & bus.reserve_conv, res_eff & ~bus.reserve_conv};
  assign dec = {pop & head_conv, pop & ~head_conv};

  // Simultaneous reserve and drain on one conveyor cancel; saturating ends flag an error.
  always_comb begin
    err_d = err_q;
    for (int c = 0; c < 2; c++) begin
      cnt_d[c] = cnt_q[c];
      if (inc[c] && !dec[c]) begin
        if (cnt_q[c] == CntMax) err_d = 1'b1;
        else cnt_d[c] = cnt_q[c] + 1'b1;
      end else if (dec[c] && !inc[c]) begin
        if (cnt_q[c] == '0) err_d = 1'b1;
        else cnt_d[c] = cnt_q[c] - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      rr_q     <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
      err_q    <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q  <= count_d;
      rr_q     <= rr_d;
      cnt_q[0] <= cnt_d[0];
      cnt_q[1] <= cnt_d[1];
      err_q    <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_entry;
  end

  assign outstanding0_o   = cnt_q[0];
  assign outstanding1_o   = cnt_q[1];
  assign protocol_error_o = err_q;
endmodule

// File: tb/tb_conveyor_writer.sv
// Randomised and directed stimulus against a queue-based reference model; a separate monitor
// compares every write-port cycle against the expectations the stimulus pushes.
module tb_conveyor_writer;
  localparam int WW = 32;
  localparam int CAW = 4;
  localparam int FAW = 3;

  typedef struct {
    logic          conv;
    logic [CAW-1:0] slot;
    logic [FAW-1:0] fault;
    logic [WW-1:0]  value;
  } cmp_t;

  typedef struct {
    logic             en;
    logic             conv;
    logic [CAW-1:0]   slot;
    logic [FAW+WW:0]  data;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  logic [CAW:0] outstanding0, outstanding1;
  logic protocol_error;

  conveyor_writer_if #(.WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CAW), .FAULT_ADDR_WIDTH(FAW),
                       .SOURCES(2)) ifc ();

  conveyor_writer #(.WORD_WIDTH(WW), .CONVEYOR_ADDR_WIDTH(CAW), .FAULT_ADDR_WIDTH(FAW),
                    .SOURCES(2), .FIFO_ADDR_WIDTH(2)) dut (
    .clk              (clk),
    .reset            (reset),
    .bus              (ifc),
    .outstanding0_o   (outstanding0),
    .outstanding1_o   (outstanding1),
    .protocol_error_o (protocol_error)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];

  // Reference model state
  cmp_t mq[$];
  int   m_rr;
  int   m_cnt[2];
  bit   m_err;
  bit   state_known = 0;

  // Stimulus for the next cycle
  logic           d_rst, d_res, d_rconv;
  logic [CAW-1:0] d_rslot;
  logic [1:0]     d_valid, d_conv;
  logic [CAW-1:0] d_slot[2];
  logic [FAW-1:0] d_fault[2];
  logic [WW-1:0]  d_val[2];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] req);
    checks++;
    if (got !== req) begin
      failures++;
      $display("FAIL %s: got %0h required %0h", name, got, req);
    end
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      checks++;
      if (ifc.wr_en !== mon_e.en || (mon_e.en && (ifc.wr_conv !== mon_e.conv ||
          ifc.wr_slot !== mon_e.slot || ifc.wr_data !== mon_e.data))) begin
        failures++;
        $display("FAIL write: got en=%0b conv=%0b slot=%0d data=%h required en=%0b conv=%0b slot=%0d data=%h",
                 ifc.wr_en, ifc.wr_conv, ifc.wr_slot, ifc.wr_data,
                 mon_e.en, mon_e.conv, mon_e.slot, mon_e.data);
      end
    end
  end

  task automatic idle();
    d_res = 0; d_rconv = 0; d_rslot = '0; d_valid = '0; d_conv = '0;
    for (int s = 0; s < 2; s++) begin
      d_slot[s] = '0; d_fault[s] = '0; d_val[s] = '0;
    end
  endtask

  task automatic step();
    exp_t e;
    cmp_t h;
    cmp_t n;
    bit   popping, found;
    int   g;
    logic [1:0] rdy;
    @(posedge clk);
    #1;
    if (state_known) begin
      chk("outstanding0", 64'(outstanding0), 64'(m_cnt[0]));
      chk("outstanding1", 64'(outstanding1), 64'(m_cnt[1]));
      chk("protocol_error", 64'(protocol_error), 64'(m_err));
    end
    reset            = d_rst;
    ifc.reserve      = d_res;
    ifc.reserve_conv = d_rconv;
    ifc.reserve_slot = d_rslot;
    ifc.src_valid    = d_valid;
    ifc.src_conv     = d_conv;
    ifc.src_slot     = {d_slot[1], d_slot[0]};
    ifc.src_fault    = {d_fault[1], d_fault[0]};
    ifc.src_value    = {d_val[1], d_val[0]};

    e = '{en: 1'b0, conv: 1'b0, slot: '0, data: '0};
    popping = 0;
    found = 0;
    g = 0;
    rdy = '0;
    if (!d_rst) begin
      if (d_res) begin
        e = '{en: 1'b1, conv: d_rconv, slot: d_rslot, data: '0};
      end else if (mq.size() > 0) begin
        h = mq[0];
        popping = 1;
        e = '{en: 1'b1, conv: h.conv, slot: h.slot, data: {1'b1, h.fault, h.value}};
      end
      if (mq.size() < 4 || popping) begin
        for (int i = 0; i < 2; i++) begin
          if (!found && d_valid[(m_rr + i) % 2]) begin
            found = 1;
            g = (m_rr + i) % 2;
          end
        end
      end
      if (found) rdy[g] = 1'b1;
    end
    exp_q.push_back(e);

    @(negedge clk);
    chk("src_ready", 64'(ifc.src_ready), 64'(rdy));

    if (d_rst) begin
      mq.delete();
      m_rr = 0;
      m_cnt[0] = 0;
      m_cnt[1] = 0;
      m_err = 0;
      state_known = 1;
    end else begin
      for (int c = 0; c < 2; c++) begin
        bit up, down;
        up = d_res && (int'(d_rconv) == c);
        down = popping && (int'(h.conv) == c);
        if (up && !down) begin
          if (m_cnt[c] == 16) m_err = 1; else m_cnt[c]++;
        end else if (down && !up) begin
          if (m_cnt[c] == 0) m_err = 1; else m_cnt[c]--;
        end
      end
      if (popping) void'(mq.pop_front());
      if (found) begin
        n = '{conv: d_conv[g], slot: d_slot[g], fault: d_fault[g], value: d_val[g]};
        mq.push_back(n);
        m_rr = (g + 1) % 2;
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    ifc.reserve = 0; ifc.reserve_conv = 0; ifc.reserve_slot = '0;
    ifc.src_valid = '0; ifc.src_conv = '0; ifc.src_slot = '0;
    ifc.src_value = '0; ifc.src_fault = '0;
    idle();
    d_rst = 1;
    repeat (2) step();
    d_rst = 0;

    // Reserve conv0 slot 15, then complete it from source 0
    d_res = 1; d_rconv = 0; d_rslot = 4'd15;
    step();
    idle();
    d_valid = 2'b01; d_conv[0] = 0; d_slot[0] = 4'd15; d_val[0] = 32'hDEADBEEF;
    step();
    idle();
    repeat (2) step();

    // Both sources valid while reserve holds the port: FIFO fills, then drains in grant order
    for (int k = 0; k < 6; k++) begin
      d_res = 1; d_rconv = k[0]; d_rslot = 4'(k);
      d_valid = 2'b11; d_conv = 2'b10;
      d_slot[0] = 4'(k); d_slot[1] = 4'(k + 8);
      d_val[0] = 32'h1000 + k; d_val[1] = 32'h2000 + k;
      step();
    end
    idle();
    repeat (6) step();

    // Faulted completion from source 1 into conv1 slot 2
    d_res = 1; d_rconv = 1; d_rslot = 4'd2;
    step();
    idle();
    d_valid = 2'b10; d_conv[1] = 1; d_slot[1] = 4'd2; d_fault[1] = 3'd3; d_val[1] = 32'hCAFE;
    step();
    idle();
    repeat (2) step();

    // Reservation and FIFO head target the same slot in the same cycle
    d_valid = 2'b01; d_conv[0] = 0; d_slot[0] = 4'd5; d_val[0] = 32'h55;
    step();
    idle();
    d_res = 1; d_rconv = 0; d_rslot = 4'd5;
    step();
    idle();
    repeat (2) step();

    // Completion with nothing outstanding, then reset while the FIFO is full
    d_rst = 1;
    step();
    d_rst = 0;
    d_valid = 2'b01; d_conv[0] = 0; d_slot[0] = 4'd7; d_val[0] = 32'h77;
    step();
    idle();
    repeat (3) step();
    for (int k = 0; k < 5; k++) begin
      d_res = 1; d_rconv = 1; d_rslot = 4'(k);
      d_valid = 2'b11; d_val[0] = 32'(k); d_val[1] = 32'(k + 100);
      step();
    end
    idle();
    d_rst = 1;
    step();
    d_rst = 0;
    repeat (3) step();

    // Random traffic
    for (int k = 0; k < 600; k++) begin
      d_rst = ($urandom_range(0, 149) == 0);
      d_res = ($urandom_range(0, 3) == 0);
      d_rconv = 1'($urandom);
      d_rslot = 4'($urandom);
      d_valid = 2'($urandom);
      d_conv = 2'($urandom);
      for (int s = 0; s < 2; s++) begin
        d_slot[s] = 4'($urandom);
        d_fault[s] = 3'($urandom);
        d_val[s] = $urandom;
      end
      step();
    end
    d_rst = 0;
    idle();
    repeat (6) step();

    @(posedge clk);
    @(negedge clk);
    chk("expectations_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
